// File: rtl/digit_match_pkg.sv
// Shared constants, types and FSM encoding for the digit template matcher.
package digit_match_pkg;

    localparam int N_PIX        = 121;  // 11x11 pixels, row-major, addr = row*11+col
    localparam int N_CLASSES    = 10;   // digit templates 0..9
    localparam int PIX_W        = 8;
    localparam int ACC_W        = 15;   // 121*255 = 30855 fits in 15 bits
    localparam int ADDR_W       = 7;
    localparam int CLASS_W      = 4;
    localparam int RUN_CYCLES   = N_PIX;
    localparam int DRAIN_CYCLES = 2;    // memory stage + difference stage

    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [ACC_W-1:0]   score_t;
    typedef logic [CLASS_W-1:0] class_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        CMP,
        DONE
    } state_t;

    typedef struct packed {
        class_t cls;
        score_t score;
    } best_t;

endpackage

// File: rtl/abs_diff_acc.sv
// Registered absolute pixel difference feeding a clearable score accumulator.
module abs_diff_acc
    import digit_match_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic [ACC_W-1:0] acc
);

    pix_t diff_q;
    logic add_q;

    // Difference stage: capture |a-b| whenever a valid pixel pair arrives.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            diff_q <= '0;
            add_q  <= 1'b0;
        end else begin
            add_q <= en;
            if (en) begin
                diff_q <= (a >= b) ? (a - b) : (b - a);
            end
        end
    end

    // Accumulate stage: clear starts a new class, otherwise add the registered difference.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add_q) begin
            acc <= acc + ACC_W'(diff_q);
        end
    end

endmodule

// File: rtl/digit_match_scheduler.sv
// Time-multiplexes one difference/accumulate unit across all ten digit templates
// and reports the lowest-scoring class with a threshold match flag.
module digit_match_scheduler
    import digit_match_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [ACC_W-1:0] match_thr,
    output logic [6:0]       img_addr,
    input  logic [PIX_W-1:0] img_data,
    output logic [3:0]       tpl_class,
    output logic [6:0]       tpl_addr,
    input  logic [PIX_W-1:0] tpl_data,
    output logic             busy,
    output logic             done,
    output logic [3:0]       best_class,
    output logic [ACC_W-1:0] best_score,
    output logic             match
);

    state_t state, next_state;
    addr_t  cnt;
    class_t class_cnt;
    score_t thr_q;
    score_t acc;
    best_t  running_best, new_best;
    logic   rd_valid;
    logic   acc_clear;
    logic   last_class;

    assign last_class = (class_cnt == class_t'(N_CLASSES - 1));
    assign tpl_class  = class_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic: RUN sweeps pixels, DRAIN flushes the pipeline, CMP picks the next class.
    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (cnt == addr_t'(RUN_CYCLES - 1)) next_state = DRAIN;
            DRAIN:   if (cnt == addr_t'(DRAIN_CYCLES - 1)) next_state = CMP;
            CMP:     next_state = last_class ? DONE : RUN;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: addresses only sweep during RUN, parked at zero otherwise.
    always_comb begin
        busy      = (state == RUN) || (state == DRAIN) || (state == CMP);
        done      = (state == DONE);
        img_addr  = '0;
        tpl_addr  = '0;
        acc_clear = 1'b0;
        if (state == RUN) begin
            img_addr  = cnt;
            tpl_addr  = cnt;
            acc_clear = (cnt == '0);
        end
    end

    // Cycle counter shared by RUN (pixel index) and DRAIN; restarts on every state change.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (next_state != state) begin
            cnt <= '0;
        end else if (state == RUN || state == DRAIN) begin
            cnt <= cnt + 7'd1;
        end
    end

    // Class counter advances at each compare; threshold is captured when a run is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            class_cnt <= '0;
            thr_q     <= '0;
        end else begin
            if (state == IDLE && start) thr_q <= match_thr;
            if (state == CMP) class_cnt <= last_class ? '0 : class_cnt + 4'd1;
        end
    end

    // Read-data valid flag: memory data lags the issued address by one cycle.
    always_ff @(posedge clk) begin
        if (reset) rd_valid <= 1'b0;
        else       rd_valid <= (state == RUN);
    end

    abs_diff_acc u_abs_diff_acc (
        .clk   (clk),
        .reset (reset),
        .clear (acc_clear),
        .en    (rd_valid),
        .a     (img_data),
        .b     (tpl_data),
        .acc   (acc)
    );

    // Candidate best: class 0 seeds it; later classes win only on a strictly lower score.
    always_comb begin
        new_best = running_best;
        if (class_cnt == '0 || acc < running_best.score) begin
            new_best = '{cls: class_cnt, score: acc};
        end
    end

    // Best tracking; visible results change only when the final class is compared.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_best <= '0;
            best_class   <= '0;
            best_score   <= '0;
            match        <= 1'b0;
        end else if (state == CMP) begin
            running_best <= new_best;
            if (last_class) begin
                best_class <= new_best.cls;
                best_score <= new_best.score;
                match      <= (new_best.score <= thr_q);
            end
        end
    end

endmodule

// File: tb/tb_digit_match_scheduler.sv
// Bench for digit_match_scheduler: synchronous-read memory models, a reference
// scoring model feeding a result scoreboard, and per-scenario tasks.
module tb_digit_match_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [14:0] match_thr;
    logic [6:0]  img_addr;
    logic [7:0]  img_data;
    logic [3:0]  tpl_class;
    logic [6:0]  tpl_addr;
    logic [7:0]  tpl_data;
    logic        busy;
    logic        done;
    logic [3:0]  best_class;
    logic [14:0] best_score;
    logic        match;

    digit_match_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .match_thr  (match_thr),
        .img_addr   (img_addr),
        .img_data   (img_data),
        .tpl_class  (tpl_class),
        .tpl_addr   (tpl_addr),
        .tpl_data   (tpl_data),
        .busy       (busy),
        .done       (done),
        .best_class (best_class),
        .best_score (best_score),
        .match      (match)
    );

    always #5 clk = ~clk;

    logic [7:0] img_mem [0:127];
    logic [7:0] tpl_mem [0:15][0:127];

    // Synchronous-read memories: data valid the cycle after the address.
    always @(posedge clk) begin
        img_data <= img_mem[img_addr];
        tpl_data <= tpl_mem[tpl_class][tpl_addr];
    end

    typedef struct {
        int cls;
        int score;
        bit hit;
    } result_t;

    result_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int prev_cls = 0;
    int prev_score = 0;
    bit prev_hit = 1'b0;
    int cyc;

    function automatic int model_score(int c);
        int s = 0;
        for (int p = 0; p < 121; p++) begin
            int d = int'(img_mem[p]) - int'(tpl_mem[c][p]);
            s += (d < 0) ? -d : d;
        end
        return s;
    endfunction

    task automatic push_expected(input int thr);
        result_t r;
        r.cls   = 0;
        r.score = model_score(0);
        for (int c = 1; c < 10; c++) begin
            int s = model_score(c);
            if (s < r.score) begin
                r.cls   = c;
                r.score = s;
            end
        end
        r.hit = (r.score <= thr);
        sb.push_back(r);
    endtask

    task automatic clear_mems();
        for (int p = 0; p < 128; p++) begin
            img_mem[p] = 8'd0;
            for (int c = 0; c < 16; c++) tpl_mem[c][p] = 8'd0;
        end
    endtask

    // Distinct pseudo-random templates; image is an exact copy of template k.
    task automatic load_copy(input int k);
        clear_mems();
        for (int c = 0; c < 10; c++)
            for (int p = 0; p < 121; p++) tpl_mem[c][p] = 8'((c * 37 + p * 13 + (p * p) % 7) & 255);
        for (int p = 0; p < 121; p++) img_mem[p] = tpl_mem[k][p];
    endtask

    // Templates 2 and 7 both score 500 (one above, one below the image); others score >= 600.
    task automatic load_tie();
        clear_mems();
        for (int p = 0; p < 121; p++) begin
            img_mem[p] = 8'd100;
            for (int c = 0; c < 10; c++) tpl_mem[c][p] = 8'd100;
        end
        for (int p = 0; p < 5; p++)   tpl_mem[2][p] = 8'd200;
        for (int p = 10; p < 20; p++) tpl_mem[7][p] = 8'd50;
        for (int c = 0; c < 10; c++)
            if (c != 2 && c != 7)
                for (int p = 0; p < c + 6; p++) tpl_mem[c][p] = 8'd0;
    endtask

    // One classification: optional ignored start pulses at cycles pa/pb, checks sweep, hold, timing, result.
    task automatic run_one(input int thr, input int pa, input int pb);
        int addr_errs = 0, busy_errs = 0, hold_errs = 0, done_cyc = -1;
        int bad_cyc = -1;
        bit busy_at_done = 1'b1;
        result_t exp_r;
        push_expected(thr);
        match_thr = 15'(thr);
        start = 1'b1;
        cyc = 0;
        while (done_cyc < 0 && cyc < 1300) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == pa) || (cyc == pb);
            if (done === 1'b1) begin
                done_cyc = cyc;
                busy_at_done = busy;
            end else begin
                int k = (cyc - 1) / 124;
                int p = (cyc - 1) % 124;
                if (busy !== 1'b1) busy_errs++;
                if (best_class !== 4'(prev_cls) || best_score !== 15'(prev_score) || match !== prev_hit)
                    hold_errs++;
                if (p < 121 && k < 10 && (img_addr !== 7'(p) || tpl_addr !== 7'(p) || tpl_class !== 4'(k))) begin
                    if (bad_cyc < 0) bad_cyc = cyc;
                    addr_errs++;
                end
            end
        end
        n_cmp++;
        if (addr_errs != 0) begin
            n_bad++;
            $display("FAIL addr_sweep: %0d bad cycles (first at %0d), want 0", addr_errs, bad_cyc);
        end
        n_cmp++;
        if (busy_errs != 0) begin
            n_bad++;
            $display("FAIL busy_during_run: %0d cycles low, want 0", busy_errs);
        end
        n_cmp++;
        if (hold_errs != 0) begin
            n_bad++;
            $display("FAIL result_hold: %0d cycles changed, want 0", hold_errs);
        end
        n_cmp++;
        if (done_cyc != 1241) begin
            n_bad++;
            $display("FAIL done_cycle: got %0d, want 1241", done_cyc);
        end
        n_cmp++;
        if (busy_at_done !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_at_done: got %0b, want 0", busy_at_done);
        end
        exp_r = sb.pop_front();
        n_cmp++;
        if (best_class !== 4'(exp_r.cls)) begin
            n_bad++;
            $display("FAIL best_class: got %0d, want %0d", best_class, exp_r.cls);
        end
        n_cmp++;
        if (best_score !== 15'(exp_r.score)) begin
            n_bad++;
            $display("FAIL best_score: got %0d, want %0d", best_score, exp_r.score);
        end
        n_cmp++;
        if (match !== exp_r.hit) begin
            n_bad++;
            $display("FAIL match: got %0b, want %0b", match, exp_r.hit);
        end
        prev_cls   = exp_r.cls;
        prev_score = exp_r.score;
        prev_hit   = exp_r.hit;
        // Cycle after done: done must have dropped and nothing relaunched.
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL after_done: done=%0b busy=%0b, want 0 0", done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        match_thr = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, best_class, best_score, match} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: busy=%0b done=%0b cls=%0d score=%0d match=%0b, want all 0",
                     busy, done, best_class, best_score, match);
        end
        n_cmp++;
        if ({img_addr, tpl_addr, tpl_class} !== '0) begin
            n_bad++;
            $display("FAIL reset_addr: img=%0d tpl=%0d cls=%0d, want 0 0 0", img_addr, tpl_addr, tpl_class);
        end
        reset = 1'b0;
        prev_cls = 0; prev_score = 0; prev_hit = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_exact_match();
        load_copy(3);
        run_one(0, -1, -1);
    endtask

    task automatic test_saturation();
        clear_mems();
        for (int p = 0; p < 121; p++) img_mem[p] = 8'd255;
        run_one(1000, -1, -1);
    endtask

    task automatic test_tie();
        load_tie();
        run_one(500, -1, -1);
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0, busy_seen = 0;
        load_copy(6);
        push_expected(0);
        match_thr = '0;
        start = 1'b1;
        cyc = 0;
        while (cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        void'(sb.pop_front());
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_busy: busy=%0b done=%0b, want 0 0", busy, done);
        end
        n_cmp++;
        if ({best_class, best_score, match} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: cls=%0d score=%0d match=%0b, want 0 0 0", best_class, best_score, match);
        end
        n_cmp++;
        if ({img_addr, tpl_addr, tpl_class} !== '0) begin
            n_bad++;
            $display("FAIL midreset_addr: img=%0d tpl=%0d cls=%0d, want 0 0 0", img_addr, tpl_addr, tpl_class);
        end
        prev_cls = 0; prev_score = 0; prev_hit = 1'b0;
        repeat (1300) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
            if (busy === 1'b1) busy_seen++;
        end
        n_cmp++;
        if (done_seen != 0 || busy_seen != 0) begin
            n_bad++;
            $display("FAIL midreset_no_done: done=%0d busy=%0d cycles, want 0 0", done_seen, busy_seen);
        end
        load_tie();
        run_one(499, -1, -1);
    endtask

    task automatic test_back_to_back();
        load_copy(5);
        run_one(10, 10, 1241);
        run_one(0, -1, -1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        match_thr = '0;
        clear_mems();
        test_reset();
        test_exact_match();
        test_saturation();
        test_tie();
        test_reset_mid_run();
        test_back_to_back();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: %0d left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/digit_match_scheduler.md
Name: digit_match_scheduler

Overview:
- Sequences a single shared pixel-difference/accumulate datapath over all ten digit templates for one 11x11 candidate image.
- Reads the candidate image and the template ROM through synchronous-read memory ports; sums per-pixel absolute differences for each class.
- Reports the class with the minimum total score plus a threshold-based match flag.
- Replaces ten fully parallel 121-instance difference arrays with one time-multiplexed unit; sits between the digit-capture buffer and the game/score logic.

Parameters:
- N_PIX, 121, pixels per image (11x11), row-major order, address = row*11+col
- N_CLASSES, 10, number of digit templates (classes 0..9)
- PIX_W, 8, pixel width in bits
- ACC_W, 15, score width; must satisfy N_PIX*(2^PIX_W-1) <= 2^ACC_W-1 (30855 fits)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request classification; sampled only in IDLE
- match_thr  in  ACC_W  maximum score accepted as a valid match; sampled at start
- img_addr  out  7  candidate image read address
- img_data  in  PIX_W  image pixel; valid the cycle after img_addr
- tpl_class  out  4  template ROM class select
- tpl_addr  out  7  template ROM pixel address
- tpl_data  in  PIX_W  template pixel; valid the cycle after tpl_class/tpl_addr
- busy  out  1  high while a classification is in progress
- done  out  1  one-cycle pulse when results update
- best_class  out  4  winning class
- best_score  out  ACC_W  winning class score
- match  out  1  best_score <= latched match_thr

Behaviour:
- Reset values: busy=0, done=0, best_class=0, best_score=0, match=0, img_addr=0, tpl_addr=0, tpl_class=0; FSM returns to IDLE.
- Reset has priority over every other event. A reset mid-run aborts the run, produces no done, and clears all outputs.
- States and transitions:
  - IDLE -> RUN when start=1.
  - RUN: 121 cycles, issuing addresses 0..120 to both ports.
  - DRAIN: 2 cycles, flushing the memory stage and the accumulate stage.
  - CMP: 1 cycle. If class<9, go to RUN for the next class; otherwise go to DONE.
  - DONE: 1 cycle, then IDLE.
- Datapath pipeline: stage 1 issues addresses, stage 2 returns data, stage 3 computes acc += |img_data - tpl_data|.
  - The difference is unsigned, PIX_W bits, zero-extended to ACC_W.
  - The accumulator clears on the first RUN cycle of each class.
  - The accumulator cannot overflow by construction.
- CMP: for class 0, load running_best={0, acc}. For later classes, replace running_best only if acc < running_best score (strictly less). Ties therefore resolve to the lowest class index.
- Timing, with start sampled at cycle 0:
  - Class k occupies cycles 124k+1 .. 124k+124.
  - busy is high in cycles 1..1240.
  - done=1 at cycle 1241, with busy=0; best_class, best_score and match update in the same cycle.
- Outputs hold the previous result throughout a run and change only on done.
- start while busy, or in the DONE cycle, is ignored and not queued. start held high in IDLE after DONE begins a new run.
- tpl_class equals the current class during RUN; its value outside RUN is don't-care but must be stable.

Decomposition:
- Package digit_match_pkg holds:
  - N_PIX, N_CLASSES, PIX_W, ACC_W
  - typedefs pix_t, score_t, class_t
  - state enum {IDLE, RUN, DRAIN, CMP, DONE}
  - RUN_CYCLES=121, DRAIN_CYCLES=2
- One sub-module, abs_diff_acc: registered |a-b| plus accumulator, with clear and enable inputs. The FSM, counters and best-tracking stay in the top module.

Test Plan:
- Image = template 3 exactly; other templates differ; match_thr=0 -> done at cycle 1241, best_class=3, best_score=0, match=1.
- Image all 255, all templates all 0 -> best_class=0, best_score=30855, match=0 with match_thr=1000.
- Templates 2 and 7 give equal minimum score 500; all others give more -> best_class=2, best_score=500.
- Reset pulse at cycle 500 -> busy=0 next cycle, all outputs 0, no done. A restart then completes at 1241 cycles after the new start with the correct result.
- start re-asserted at cycles 10 and 1241 during a run -> ignored, exactly one done. start at cycle 1242 launches a second run.
- Memory model checks that img_addr and tpl_addr sweep 0..120 contiguously and tpl_class steps 0..9 once per run, with no reads during DRAIN or CMP.
